// File: rtl/daq_chain_arbiter_pkg.sv
// Shared types and framing constants for the DAQ chain arbiter.
// The optional trailer word is enabled with the DAQ_ARB_TRAILER_EN macro.
package daq_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    DATA    = 2'd2,
    TRAILER = 2'd3
  } arbState_t;

  localparam int         FIFO_WIDTH  = 16;
  localparam logic [7:0] HEADER_TAG  = 8'hCA;
  localparam logic [3:0] TRAILER_TAG = 4'hE;

endpackage

// File: rtl/daq_chain_arbiter_if.sv
// Chain streams and USB FIFO write port shared by the arbiter and its environment.
// Chain handshake: a word moves on a cycle where ChainValid[i] & ChainReady[i] are both high;
// ChainLast[i] only counts on such a cycle; the FIFO takes one word per ExternalFifoDataEnable pulse.
interface daq_chain_arbiter_if
  import daq_arb_pkg::*;
#(
  parameter int NUM_CHAINS = 4,
  parameter int DATA_WIDTH = FIFO_WIDTH
);
  logic                             ArbEnable;
  logic [NUM_CHAINS*DATA_WIDTH-1:0] ChainData;
  logic [NUM_CHAINS-1:0]            ChainValid;
  logic [NUM_CHAINS-1:0]            ChainLast;
  logic [NUM_CHAINS-1:0]            ChainReady;
  logic                             ExternalFifoFull;
  logic [DATA_WIDTH-1:0]            ExternalFifoData;
  logic                             ExternalFifoDataEnable;
  logic [1:0]                       GrantId;
  logic                             Busy;

  modport master (
    input  ArbEnable, ChainData, ChainValid, ChainLast, ExternalFifoFull,
    output ChainReady, ExternalFifoData, ExternalFifoDataEnable, GrantId, Busy
  );

  modport slave (
    output ArbEnable, ChainData, ChainValid, ChainLast, ExternalFifoFull,
    input  ChainReady, ExternalFifoData, ExternalFifoDataEnable, GrantId, Busy
  );
endinterface

// File: rtl/daq_chain_arbiter_rr_grant_select.sv
// Combinational round-robin pick: the nearest requester after lastPtr wins.
module rr_grant_select
  import daq_arb_pkg::*;
#(
  parameter int NUM_CHAINS = 4
) (
  input  logic [NUM_CHAINS-1:0] req,
  input  logic [1:0]            lastPtr,
  output logic [NUM_CHAINS-1:0] grant,
  output logic [1:0]            grantIdx,
  output logic                  anyReq
);
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    anyReq   = |req;
    // Walk from the farthest candidate to the nearest so the nearest overwrites.
    for (int k = NUM_CHAINS; k >= 1; k--) begin
      if (req[(int'(lastPtr) + k) % NUM_CHAINS]) begin
        grant    = NUM_CHAINS'(1) << ((int'(lastPtr) + k) % NUM_CHAINS);
        grantIdx = 2'((int'(lastPtr) + k) % NUM_CHAINS);
      end
    end
  end
endmodule

// File: rtl/daq_chain_arbiter.sv
// Round-robin arbiter framing packets from up to four readout chains into one FIFO port.
// DAQ_ARB_TRAILER_EN adds a trailer word {E, count[11:0]} after each packet.
module daq_chain_arbiter
  import daq_arb_pkg::*;
#(
  parameter int NUM_CHAINS = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                Clk,
  input  logic                reset_n,
  daq_chain_arbiter_if.master bus,
  output arbState_t           ArbState
);
  arbState_t state, stateNext;
  logic [1:0]            lastPtr;
  logic [1:0]            grantId;
  logic [NUM_CHAINS-1:0] grantMask;
  logic [NUM_CHAINS-1:0] rrGrant;
  logic [1:0]            rrIdx;
  logic                  rrAny;
  logic [DATA_WIDTH-1:0] grantedData;
  logic                  grantedValid, grantedLast;
  logic                  doGrant, writeHeader, doTransfer, writeTrailer;
  logic [NUM_CHAINS-1:0] chainReady;
  logic [DATA_WIDTH-1:0] fifoData;
  logic                  fifoEn, busy;

  rr_grant_select #(.NUM_CHAINS(NUM_CHAINS)) uSelect (
    .req      (bus.ChainValid),
    .lastPtr  (lastPtr),
    .grant    (rrGrant),
    .grantIdx (rrIdx),
    .anyReq   (rrAny)
  );

  assign grantedData  = bus.ChainData[grantId*DATA_WIDTH +: DATA_WIDTH];
  assign grantedValid = |(bus.ChainValid & grantMask);
  assign grantedLast  = |(bus.ChainLast & grantMask);

  always_comb begin
    stateNext    = state;
    doGrant      = 1'b0;
    writeHeader  = 1'b0;
    doTransfer   = 1'b0;
    writeTrailer = 1'b0;
    chainReady   = '0;
    case (state)
      IDLE: if (bus.ArbEnable && rrAny) begin
        doGrant   = 1'b1;
        stateNext = HEADER;
      end
      HEADER: if (!bus.ExternalFifoFull) begin
        writeHeader = 1'b1;
        stateNext   = DATA;
      end
      DATA: begin
        chainReady = grantMask & {NUM_CHAINS{~bus.ExternalFifoFull}};
        if (grantedValid && !bus.ExternalFifoFull) begin
          doTransfer = 1'b1;
          if (grantedLast) begin
`ifdef DAQ_ARB_TRAILER_EN
            stateNext = TRAILER;
`else
            stateNext = IDLE;
`endif
          end
        end
      end
`ifdef DAQ_ARB_TRAILER_EN
      TRAILER: if (!bus.ExternalFifoFull) begin
        writeTrailer = 1'b1;
        stateNext    = IDLE;
      end
`endif
      default: stateNext = IDLE;
    endcase
  end

`ifdef DAQ_ARB_TRAILER_EN
  logic [11:0] wordCount;

  // Count wraps at 4096; the trailer carries the low 12 bits including the last word.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n)         wordCount <= '0;
    else if (writeHeader) wordCount <= '0;
    else if (doTransfer)  wordCount <= wordCount + 12'd1;
  end
`endif

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      lastPtr   <= 2'(NUM_CHAINS - 1);
      grantId   <= '0;
      grantMask <= '0;
      busy      <= 1'b0;
      fifoData  <= '0;
      fifoEn    <= 1'b0;
    end else begin
      state  <= stateNext;
      busy   <= (stateNext != IDLE);
      fifoEn <= writeHeader | doTransfer | writeTrailer;
      if (doGrant) begin
        grantId   <= rrIdx;
        grantMask <= rrGrant;
        lastPtr   <= rrIdx;
      end
      if (writeHeader) fifoData <= {HEADER_TAG, 6'b0, grantId};
      else if (doTransfer) fifoData <= grantedData;
`ifdef DAQ_ARB_TRAILER_EN
      else if (writeTrailer) fifoData <= {TRAILER_TAG, wordCount};
`endif
    end
  end

  assign bus.ChainReady             = chainReady;
  assign bus.ExternalFifoData       = fifoData;
  assign bus.ExternalFifoDataEnable = fifoEn;
  assign bus.GrantId                = grantId;
  assign bus.Busy                   = busy;
  assign ArbState                   = state;
endmodule

// File: tb/tb_daq_chain_arbiter.sv
// Bench for daq_chain_arbiter: random chain traffic against a packet-level round-robin model.
// Expectations follow DAQ_ARB_TRAILER_EN the same way the design does.
module tb_daq_chain_arbiter;
  import daq_arb_pkg::*;

  localparam int N = 4;
  typedef struct { logic [15:0] d; logic l; } word_t;

`ifdef DAQ_ARB_TRAILER_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif

  logic      Clk = 1'b0;
  logic      reset_n;
  arbState_t ArbState;

  daq_chain_arbiter_if #(.NUM_CHAINS(N)) bus();

  daq_chain_arbiter #(.NUM_CHAINS(N), .DATA_WIDTH(16)) dut (
    .Clk      (Clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .ArbState (ArbState)
  );

  always #5 Clk = ~Clk;

  int          vectors = 0;
  int          miscompares = 0;
  word_t       drv_q[N][$];
  word_t       mdl_q[N][$];
  logic [N-1:0] mid;
  int          mdl_ptr;
  logic [15:0] got_q[$];
  int          got_t[$];
  logic [15:0] exp_q[$];
  int          viol;
  bit          timed_out;
  logic        prev_full = 1'b0;

  task automatic start_test();
    got_q.delete(); got_t.delete(); exp_q.delete(); viol = 0;
  endtask

  task automatic load_pkt(input int c, input int len, input int base);
    word_t w;
    for (int k = 0; k < len; k++) begin
      w.d = (base >= 0) ? 16'(base + k) : 16'($urandom);
      w.l = (k == len - 1);
      drv_q[c].push_back(w);
      mdl_q[c].push_back(w);
    end
  endtask

  // Packet-level model: serve pending packets in round-robin order after the last winner.
  function automatic void build_expected();
    int id;
    int cnt;
    word_t w;
    while (1) begin
      id = -1;
      for (int k = 1; k <= N; k++)
        if (id < 0 && mdl_q[(mdl_ptr + k) % N].size() > 0) id = (mdl_ptr + k) % N;
      if (id < 0) break;
      exp_q.push_back({8'hCA, 6'b0, 2'(id)});
      cnt = 0;
      do begin
        w = mdl_q[id].pop_front();
        exp_q.push_back(w.d);
        cnt++;
      end while (!w.l);
      if (TRL == 1) exp_q.push_back({4'hE, 12'(cnt)});
      mdl_ptr = id;
    end
  endfunction

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int c = 0; c < N; c++) if (drv_q[c].size() > 0) e = 1'b0;
    return e;
  endfunction

  task automatic drive(input int cyc, input int gap_pct, input int full_pct, input int fa, input int fb);
    logic [N-1:0]    v;
    logic [N-1:0]    l;
    logic [N*16-1:0] d;
    for (int c = 0; c < N; c++) begin
      if (drv_q[c].size() > 0) begin
        v[c] = !(mid[c] && ($urandom_range(99) < gap_pct));
        d[c*16 +: 16] = drv_q[c][0].d;
        l[c] = drv_q[c][0].l;
      end else begin
        v[c] = 1'b0;
        d[c*16 +: 16] = 16'($urandom);
        l[c] = 1'($urandom);
      end
    end
    bus.ChainValid = v;
    bus.ChainData  = d;
    bus.ChainLast  = l;
    bus.ExternalFifoFull = (fa >= 0 && cyc >= fa && cyc < fa + 5) ||
                           (fb >= 0 && cyc >= fb && cyc < fb + 5) ||
                           ($urandom_range(99) < full_pct);
  endtask

  // stop_words > 0: stop after that many FIFO words; 0: stop when drained; < 0: run max_cyc cycles.
  task automatic run_traffic(input int max_cyc, input int stop_words, input int gap_pct,
                             input int full_pct, input int fa, input int fb);
    logic [N-1:0] fire;
    int cyc;
    bit done;
    word_t w;
    cyc = 0; done = 1'b0; timed_out = 1'b0;
    drive(cyc, gap_pct, full_pct, fa, fb);
    while (!done) begin
      @(negedge Clk);
      if (bus.ExternalFifoDataEnable === 1'b1) begin
        got_q.push_back(bus.ExternalFifoData);
        got_t.push_back(cyc);
        if (prev_full) viol++;
      end
      if (bus.ExternalFifoFull && bus.ChainReady != 0) viol++;
      if ($countones(bus.ChainReady) > 1) viol++;
      fire = bus.ChainValid & bus.ChainReady;
      prev_full = bus.ExternalFifoFull;
      if (stop_words > 0) done = (got_q.size() >= stop_words);
      else if (stop_words == 0) done = all_empty() && (bus.Busy === 1'b0);
      if (!done && cyc >= max_cyc) begin
        done = 1'b1;
        timed_out = (stop_words >= 0);
      end
      @(posedge Clk); #1;
      cyc++;
      for (int c = 0; c < N; c++)
        if (fire[c]) begin
          w = drv_q[c].pop_front();
          mid[c] = !w.l;
        end
      drive(cyc, gap_pct, full_pct, fa, fb);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.ArbEnable = 1'b1; bus.ChainValid = '0; bus.ChainData = '0;
    bus.ChainLast = '0; bus.ExternalFifoFull = 1'b0;
    mid = '0; mdl_ptr = N - 1;
    repeat (3) @(negedge Clk);
    vectors++;
    if ({bus.ChainReady, bus.ExternalFifoDataEnable, bus.ExternalFifoData, bus.GrantId, bus.Busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ready=%b en=%b data=%h gid=%0d busy=%b, expected all zero",
               bus.ChainReady, bus.ExternalFifoDataEnable, bus.ExternalFifoData, bus.GrantId, bus.Busy);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    vectors++;
    if (ArbState !== IDLE || bus.Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got state=%0d busy=%b, expected state=0 busy=0", ArbState, bus.Busy);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_single();
    start_test();
    load_pkt(0, 3, 1);
    build_expected();
    run_traffic(200, 0, 0, 0, -1, -1);
    vectors++;
    if (timed_out) begin miscompares++; $display("FAIL single_timeout: got timeout, expected drain"); end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL single_len: got %0d words, expected %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        miscompares++; $display("FAIL single_word[%0d]: got %h, expected %h", k, got_q[k], exp_q[k]);
      end
    end
    if (got_t.size() >= 2) begin
      vectors++;
      if (got_t[0] != 2 || got_t[1] != 3) begin
        miscompares++;
        $display("FAIL single_latency: got header cycle %0d data cycle %0d, expected 2 and 3", got_t[0], got_t[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int h2;
    start_test();
    load_pkt(1, 4, -1);
    load_pkt(2, 3, -1);
    build_expected();
    run_traffic(300, 0, 0, 0, -1, -1);
    vectors++;
    if (timed_out || viol != 0) begin
      miscompares++; $display("FAIL b2b_run: got timeout=%0d viol=%0d, expected 0 and 0", timed_out, viol);
    end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL b2b_len: got %0d words, expected %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        miscompares++; $display("FAIL b2b_word[%0d]: got %h, expected %h", k, got_q[k], exp_q[k]);
      end
    end
    h2 = 1 + 4 + TRL;
    if (got_t.size() > h2) begin
      vectors++;
      if (got_t[h2] != got_t[h2-1] + 2) begin
        miscompares++;
        $display("FAIL b2b_gap: got second header at cycle %0d, expected %0d", got_t[h2], got_t[h2-1] + 2);
      end
    end
    start_test();
    load_pkt(1, 2, -1);
    load_pkt(3, 2, -1);
    build_expected();
    run_traffic(300, 0, 0, 0, -1, -1);
    vectors++;
    if (got_q.size() == 0 || got_q[0] !== 16'hCA03) begin
      miscompares++; $display("FAIL b2b_rr_next: got first word %h, expected ca03", got_q.size() ? got_q[0] : 16'hxxxx);
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        miscompares++; $display("FAIL b2b2_word[%0d]: got %h, expected %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_full();
    int blocked;
    start_test();
    load_pkt(2, 12, -1);
    build_expected();
    run_traffic(300, 0, 0, 0, 1, 12);
    vectors++;
    if (timed_out || viol != 0) begin
      miscompares++; $display("FAIL full_run: got timeout=%0d viol=%0d, expected 0 and 0", timed_out, viol);
    end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL full_len: got %0d words, expected %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        miscompares++; $display("FAIL full_word[%0d]: got %h, expected %h", k, got_q[k], exp_q[k]);
      end
    end
    vectors++;
    if (got_t.size() == 0 || got_t[0] != 7) begin
      miscompares++; $display("FAIL full_header_hold: got header cycle %0d, expected 7", got_t.size() ? got_t[0] : -1);
    end
    blocked = 0;
    foreach (got_t[k]) if (got_t[k] >= 13 && got_t[k] <= 17) blocked++;
    vectors++;
    if (blocked != 0) begin
      miscompares++; $display("FAIL full_data_hold: got %0d writes during full window, expected 0", blocked);
    end
  endtask

  task automatic test_arb_enable();
    int first_size;
    start_test();
    for (int c = 0; c < N; c++) load_pkt(c, 5, -1);
    build_expected();
    first_size = 1 + 5 + TRL;
    run_traffic(100, 3, 0, 0, -1, -1);
    vectors++;
    if (timed_out) begin miscompares++; $display("FAIL enable_start: got timeout, expected 3 words"); end
    bus.ArbEnable = 1'b0;
    run_traffic(60, -1, 0, 0, -1, -1);
    vectors++;
    if (got_q.size() != first_size) begin
      miscompares++; $display("FAIL enable_hold_words: got %0d words, expected %0d", got_q.size(), first_size);
    end
    vectors++;
    if (bus.Busy !== 1'b0 || ArbState !== IDLE) begin
      miscompares++; $display("FAIL enable_hold_idle: got busy=%b state=%0d, expected 0 and 0", bus.Busy, ArbState);
    end
    bus.ArbEnable = 1'b1;
    run_traffic(600, 0, 20, 0, -1, -1);
    vectors++;
    if (timed_out || viol != 0) begin
      miscompares++; $display("FAIL enable_run: got timeout=%0d viol=%0d, expected 0 and 0", timed_out, viol);
    end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL enable_len: got %0d words, expected %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        miscompares++; $display("FAIL enable_word[%0d]: got %h, expected %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      start_test();
      for (int p = 0; p < 5; p++) load_pkt($urandom_range(N - 1), $urandom_range(8, 1), -1);
      build_expected();
      run_traffic(2000, 0, 30, 25, -1, -1);
      vectors++;
      if (timed_out || viol != 0) begin
        miscompares++; $display("FAIL random_run[%0d]: got timeout=%0d viol=%0d, expected 0 and 0", r, timed_out, viol);
      end
      vectors++;
      if (got_q.size() != exp_q.size()) begin
        miscompares++; $display("FAIL random_len[%0d]: got %0d words, expected %0d", r, got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
        vectors++;
        if (got_q[k] !== exp_q[k]) begin
          miscompares++; $display("FAIL random_word[%0d][%0d]: got %h, expected %h", r, k, got_q[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_long_packet();
    start_test();
    load_pkt(0, 4097, -1);
    build_expected();
    run_traffic(6000, 0, 0, 0, -1, -1);
    vectors++;
    if (timed_out) begin miscompares++; $display("FAIL long_timeout: got timeout, expected drain"); end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL long_len: got %0d words, expected %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        miscompares++; $display("FAIL long_word[%0d]: got %h, expected %h", k, got_q[k], exp_q[k]);
      end
    end
`ifdef DAQ_ARB_TRAILER_EN
    vectors++;
    if (got_q.size() == 0 || got_q[got_q.size()-1] !== 16'hE001) begin
      miscompares++; $display("FAIL long_wrap_trailer: got %h, expected e001", got_q.size() ? got_q[got_q.size()-1] : 16'hxxxx);
    end
`endif
  endtask

  task automatic test_reset_mid();
    start_test();
    load_pkt(2, 20, -1);
    run_traffic(200, 4, 0, 0, -1, -1);
    #2;
    reset_n = 1'b0;
    bus.ChainValid = '0;
    #1;
    vectors++;
    if ({bus.ChainReady, bus.ExternalFifoDataEnable, bus.ExternalFifoData, bus.GrantId, bus.Busy} !== '0
        || ArbState !== IDLE) begin
      miscompares++;
      $display("FAIL reset_mid_async: got ready=%b en=%b data=%h gid=%0d busy=%b state=%0d, expected all zero",
               bus.ChainReady, bus.ExternalFifoDataEnable, bus.ExternalFifoData, bus.GrantId, bus.Busy, ArbState);
    end
    for (int c = 0; c < N; c++) begin drv_q[c].delete(); mdl_q[c].delete(); end
    mid = '0; mdl_ptr = N - 1; prev_full = 1'b0;
    @(negedge Clk);
    reset_n = 1'b1;
    @(posedge Clk); #1;
    start_test();
    load_pkt(0, 3, -1);
    load_pkt(1, 2, -1);
    build_expected();
    run_traffic(300, 0, 0, 0, -1, -1);
    vectors++;
    if (got_q.size() == 0 || got_q[0] !== 16'hCA00) begin
      miscompares++; $display("FAIL reset_mid_header: got %h, expected ca00", got_q.size() ? got_q[0] : 16'hxxxx);
    end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL reset_mid_len: got %0d words, expected %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        miscompares++; $display("FAIL reset_mid_word[%0d]: got %h, expected %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_arb_enable();
    test_random();
    test_long_packet();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/daq_chain_arbiter.md
# daq_chain_arbiter

Round-robin arbiter that shares the single external USB FIFO write port between up to four MICROROC readout chains. Each chain presents its DAQ words on a valid/ready stream terminated by a last flag. The arbiter grants one chain at a time and frames every packet with a header word, and optionally a trailer word. It sits between the per-chain DAQ controllers and the USB FIFO interface.

## Interface
Parameters:
- NUM_CHAINS, 4, number of requesting chains (1..4).
- DATA_WIDTH, 16, word width; fixed to match the external FIFO.

Ports:
- Clk  input  1  system clock (40 MHz); sole clock.
- reset_n  input  1  reset, asynchronous, active-low.
- ArbEnable  input  1  allows new grants; deassertion never aborts a packet in flight.
- ChainData  input  NUM_CHAINS*16  chain i occupies bits [16i+15:16i].
- ChainValid  input  NUM_CHAINS  word present.
- ChainLast  input  NUM_CHAINS  qualifies the final word of a packet.
- ChainReady  output  NUM_CHAINS  transfer accepted when Valid&Ready.
- ExternalFifoFull  input  1  USB FIFO full.
- ExternalFifoData  output  16  word to FIFO.
- ExternalFifoDataEnable  output  1  one-cycle write strobe per word.
- GrantId  output  2  chain currently granted; valid while Busy.
- Busy  output  1  high from the grant until the last framing word is written.

## Operation
- The FSM has four states: IDLE, HEADER, DATA and TRAILER. TRAILER exists only with the macro defined.
- IDLE: if ArbEnable=1 and any ChainValid=1, grant the first requester in round-robin order, starting from (last granted + 1) mod NUM_CHAINS, then go to HEADER. The pointer resets to NUM_CHAINS-1, so chain 0 wins first.
- HEADER: when ExternalFifoFull=0, write {8'hCA, 6'b0, GrantId}, clear the word counter and go to DATA.
- DATA:
  - ChainReady[GrantId] = ~ExternalFifoFull; all other ready bits are 0.
  - Each transfer writes ChainData of the granted chain and increments the 12-bit word counter, which wraps at 4096.
  - A transfer with ChainLast goes to TRAILER if the macro is defined, otherwise to IDLE.
- TRAILER: when ExternalFifoFull=0, write {4'hE, count[11:0]}, where count includes the last word, then go to IDLE.
- Grant is held until the packet ends. There is no preemption and no timeout; a stalled granted chain blocks the others.
- A ChainValid of 0 in DATA inserts idle cycles and no write.
- ChainLast is ignored unless accompanied by Valid&Ready.
- With NUM_CHAINS=1 the arbiter always grants chain 0.

## Timing
- Reset values: ChainReady=0, ExternalFifoData=16'h0000, ExternalFifoDataEnable=0, GrantId=0, Busy=0, state IDLE, counter 0.
- Outputs to the FIFO are registered: a word accepted or generated in cycle n appears with its Enable in cycle n+1.
- ChainReady is combinational from the state, the grant and ExternalFifoFull.
- Latency from ChainValid rising in IDLE:
  - grant at edge 1;
  - header Enable in cycle 2;
  - first data transfer in cycle 2, with its Enable in cycle 3.
- Back-to-back packets: after the final framing word is issued, one IDLE cycle precedes the next grant.
- Full: ExternalFifoFull=1 blocks header, data and trailer writes in the same cycle. No word is ever dropped or duplicated.
- Simultaneous requests resolve in the same cycle by the round-robin pointer.
- Asynchronous reset mid-packet returns the block immediately to its reset values. The partial packet is lost; the host resynchronises on the header.

## Configuration
- DAQ_ARB_TRAILER_EN defined: the TRAILER state is present and each packet ends with {4'hE, count}.
- Not defined: the TRAILER state is absent, the word counter is not built, and DATA returns directly to IDLE after the last word.

## Structure
- Shared package daq_arb_pkg holds:
  - the state encoding (IDLE=2'd0, HEADER=2'd1, DATA=2'd2, TRAILER=2'd3);
  - the constants HEADER_TAG=8'hCA and TRAILER_TAG=4'hE.
- One sub-module, rr_grant_select: combinational round-robin priority select (request vector, last pointer -> one-hot grant, index, any).

## Test plan
- Single chain 0 sends 3 words 16'h0001..0003 with last on 0003. Required FIFO stream: CA00, 0001, 0002, 0003, E003 (trailer only with the macro). Busy drops after the final word.
- Chains 1 and 2 both valid in IDLE. Chain 1 is granted first; chain 2's packet starts only after chain 1's framing completes. The next simultaneous request picks chain 3 (or 0) before chain 1.
- ExternalFifoFull asserted for 5 cycles mid-DATA and during HEADER. ChainReady=0 and no Enable while full; the stream is complete with no gaps lost and no duplicates.
- ArbEnable deasserted during DATA. The current packet finishes; no new grant occurs while chains 0..3 stay valid; on re-enable, the grant resumes in round-robin order.
- A 4097-word packet with the macro defined produces a trailer of E001 (counter wrap).
- reset_n pulsed low mid-DATA. All outputs take reset values asynchronously; the next packet begins with header CA00 from chain 0.
